// File: rtl/guess_entry.sv
`timescale 1ns/1ps
// Guess entry: switch decode, debounced enter key and digit collection FSM.
// Collects DIGITS distinct switch values into a guess register.
module guess_entry #(
  parameter int NUM_SW     = 10,
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int UNIQUE     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SW-1:0]   SW,
  input  logic                enter,
  input  logic                clear,
  output logic [3:0]          cur_num,
  output logic                nonerror,
  output logic [4*DIGITS-1:0] digits,
  output logic [3:0]          count,
  output logic                valid,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic {COLLECT, FULL} state_t;

  logic [NUM_SW-1:0]   sw_s1_q, sw_s2_q;
  logic                en_s1_q, en_s2_q;
  logic [3:0]          cur_num_q, cur_num_d;
  logic                nonerror_q, nonerror_d;
  logic [CW-1:0]       deb_cnt_q, deb_cnt_d;
  logic                deb_lvl_q, deb_lvl_d;
  logic                ev_q, ev_d;
  logic [1:0]          warm_q;
  logic                armed_q, armed_d;
  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [3:0]          count_q, count_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                dup, uniq_hit, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      cur_num_q  <= 4'hF;
      nonerror_q <= 1'b0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      ev_q       <= 1'b0;
      warm_q     <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sw_s1_q    <= SW;
      sw_s2_q    <= sw_s1_q;
      en_s1_q    <= enter;
      en_s2_q    <= en_s1_q;
      cur_num_q  <= cur_num_d;
      nonerror_q <= nonerror_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      ev_q       <= ev_d;
      warm_q     <= {warm_q[0], 1'b1};
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    cur_num_d  = 4'hF;
    nonerror_d = 1'b0;
    if ($countones(sw_s2_q) == 1) begin
      nonerror_d = 1'b1;
      for (int i = 0; i < NUM_SW; i++)
        if (sw_s2_q[i]) cur_num_d = 4'(i);
    end
  end

  // A key held through reset must be released before it can fire:
  // arming waits for a genuinely low key once the synchroniser has filled.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    ev_d      = 1'b0;
    armed_d   = armed_q | (warm_q[1] & ~en_s2_q & ~deb_lvl_q);
    if (en_s2_q != deb_lvl_q) begin
      if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_lvl_d = en_s2_q;
        ev_d      = en_s2_q & armed_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (4'(k) < count_q && digits_q[4*k +: 4] == cur_num_q)
        dup = 1'b1;
  end

  assign uniq_hit = (UNIQUE != 0) && dup;
  assign accept   = ev_q & nonerror_q & ~uniq_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      digits_q   <= '1;
      count_q    <= 4'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT:
        if (!clear && accept && count_q == 4'(DIGITS - 1))
          state_d = FULL;
      FULL:
        if (clear) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    digits_d   = digits_q;
    count_d    = count_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    if (clear) begin
      digits_d   = '1;
      count_d    = 4'd0;
      err_code_d = 2'b00;
    end else if (ev_q) begin
      unique case (state_q)
        COLLECT: begin
          if (!nonerror_q) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (uniq_hit) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            for (int k = 0; k < DIGITS; k++)
              if (4'(k) == count_q) digits_d[4*k +: 4] = cur_num_q;
            count_d = count_q + 4'd1;
          end
        end
        FULL: begin
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign cur_num  = cur_num_q;
  assign nonerror = nonerror_q;
  assign digits   = digits_q;
  assign count    = count_q;
  assign valid    = (state_q == FULL);
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_guess_entry.sv
`timescale 1ns/1ps
// Scoreboard bench for guess_entry: stimulus queues expected responses,
// a negedge monitor pops one per observed output change or err pulse.
module tb_guess_entry;

  localparam int D = 16;

  typedef struct packed {
    logic        e;
    logic [1:0]  c;
    logic [3:0]  n;
    logic [15:0] d;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  SW = '0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  cur_num;
  logic        nonerror;
  logic [15:0] digits;
  logic [3:0]  count;
  logic        valid;
  logic        err;
  logic [1:0]  err_code;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t e, got;
  logic [22:0] snap, prev;

  always #5 clk = ~clk;

  guess_entry #(
    .NUM_SW(10), .DIGITS(4), .DEB_CYCLES(D), .UNIQUE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .enter(enter), .clear(clear),
    .cur_num(cur_num), .nonerror(nonerror), .digits(digits),
    .count(count), .valid(valid), .err(err), .err_code(err_code)
  );

  always @(negedge clk) begin
    snap = {err_code, count, digits, valid};
    got  = {err, err_code, count, digits, valid};
    if (rst_n && (err || snap !== prev)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got=%h", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL resp got=%h exp=%h", got, e);
        end
      end
    end
    prev = snap;
  end

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, g, x);
    end
  endtask

  task automatic push(input logic ee, input logic [1:0] c,
                      input logic [3:0] n, input logic [15:0] d,
                      input logic v);
    q.push_back({ee, c, n, d, v});
  endtask

  task automatic set_sw(input logic [9:0] v);
    SW = v;
    repeat (5) @(posedge clk);
  endtask

  task automatic press();
    @(posedge clk);
    enter = 1'b1;
    repeat (40) @(posedge clk);
    enter = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  task automatic bounce_press();
    @(posedge clk);
    for (int b = 0; b < 5; b++) begin
      enter = 1'b1;
      repeat (3) @(posedge clk);
      enter = 1'b0;
      repeat (3) @(posedge clk);
    end
    enter = 1'b1;
    repeat (40) @(posedge clk);
    enter = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  task automatic do_clear();
    @(posedge clk);
    clear = 1'b1;
    @(posedge clk);
    clear = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cur_num"}, 32'(cur_num), 32'hF);
    chk({tag, "_nonerror"}, 32'(nonerror), 32'h0);
    chk({tag, "_digits"}, 32'(digits), 32'hFFFF);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_err_code"}, 32'(err_code), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    set_sw(10'h008);
    @(negedge clk);
    chk("cur_num_3", 32'(cur_num), 32'h3);
    chk("nonerror_3", 32'(nonerror), 32'h1);
    push(1'b0, 2'b00, 4'd1, 16'hFFF3, 1'b0);
    press();

    set_sw(10'h020);
    push(1'b0, 2'b00, 4'd2, 16'hFF53, 1'b0);
    bounce_press();

    set_sw(10'h008);
    push(1'b1, 2'b10, 4'd2, 16'hFF53, 1'b0);
    press();

    set_sw(10'h00C);
    @(negedge clk);
    chk("cur_num_multi", 32'(cur_num), 32'hF);
    chk("nonerror_multi", 32'(nonerror), 32'h0);
    push(1'b1, 2'b01, 4'd2, 16'hFF53, 1'b0);
    press();

    set_sw(10'h000);
    @(negedge clk);
    chk("cur_num_zero", 32'(cur_num), 32'hF);
    push(1'b1, 2'b01, 4'd2, 16'hFF53, 1'b0);
    press();

    set_sw(10'h080);
    push(1'b0, 2'b01, 4'd3, 16'hF753, 1'b0);
    press();
    set_sw(10'h002);
    push(1'b0, 2'b01, 4'd4, 16'h1753, 1'b1);
    press();
    set_sw(10'h200);
    push(1'b1, 2'b11, 4'd4, 16'h1753, 1'b1);
    press();

    push(1'b0, 2'b00, 4'd0, 16'hFFFF, 1'b0);
    do_clear();

    set_sw(10'h004);
    push(1'b0, 2'b00, 4'd1, 16'hFFF2, 1'b0);
    press();
    set_sw(10'h200);
    push(1'b0, 2'b00, 4'd2, 16'hFF92, 1'b0);
    press();

    // clear window brackets the event cycle so they coincide
    set_sw(10'h001);
    push(1'b0, 2'b00, 4'd0, 16'hFFFF, 1'b0);
    @(posedge clk);
    enter = 1'b1;
    repeat (D + 1) @(posedge clk);
    clear = 1'b1;
    repeat (3) @(posedge clk);
    clear = 1'b0;
    repeat (40) @(posedge clk);
    enter = 1'b0;
    repeat (40) @(posedge clk);

    set_sw(10'h010);
    push(1'b0, 2'b00, 4'd1, 16'hFFF4, 1'b0);
    press();
    set_sw(10'h040);
    push(1'b0, 2'b00, 4'd2, 16'hFF64, 1'b0);
    press();
    set_sw(10'h100);
    push(1'b0, 2'b00, 4'd3, 16'hF864, 1'b0);
    press();

    set_sw(10'h008);
    @(posedge clk);
    enter = 1'b1;
    repeat (8) @(posedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("midrst");
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("held_count", 32'(count), 32'h0);
    chk("held_err_code", 32'(err_code), 32'h0);
    enter = 1'b0;
    repeat (40) @(posedge clk);
    push(1'b0, 2'b00, 4'd1, 16'hFFF3, 1'b0);
    press();

    repeat (20) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
